// File: rtl/digit_seq_ctrl_if.sv
// Step-sequencer bundle: raw button/mode/direction in, step strobe, direction,
// index and synchronized mode out.
interface digit_seq_ctrl_if;
  logic       key_step_n;
  logic       auto_en;
  logic       dir_up;
  logic       step;
  logic       step_up;
  logic [2:0] idx;
  logic       auto_active;

  modport master (output key_step_n, auto_en, dir_up,
                  input  step, step_up, idx, auto_active);
  modport slave  (input  key_step_n, auto_en, dir_up,
                  output step, step_up, idx, auto_active);
endinterface

// File: rtl/digit_seq_ctrl.sv
// Display step sequencer: debounced push-button or periodic auto tick drives
// a wrapping index with a one-cycle step strobe.
module digit_seq_ctrl #(
  parameter int NUM_STATES      = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_CYCLES     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  digit_seq_ctrl_if.slave  bus
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [2:0]    IDX_LAST  = 3'(NUM_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRESS_DB, S_HELD, S_REL_DB} db_state_t;

  logic          ks_m, ks;
  logic          au_m, auto_active_r;
  db_state_t     state;
  logic [CW-1:0] cnt;
  logic          press_ok;
  logic [TW-1:0] tcnt;
  logic          tick, src;
  logic          step_r, step_up_r;
  logic [2:0]    idx_r, idx_nxt;

  // Button idles released (1), so the synchronizer resets high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ks_m          <= 1'b1;
      ks            <= 1'b1;
      au_m          <= 1'b0;
      auto_active_r <= 1'b0;
    end else begin
      ks_m          <= bus.key_step_n;
      ks            <= ks_m;
      au_m          <= bus.auto_en;
      auto_active_r <= au_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      press_ok <= 1'b0;
    end else begin
      press_ok <= 1'b0;
      case (state)
        S_IDLE:
          if (!ks) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state    <= S_HELD;
              cnt      <= '0;
              press_ok <= 1'b1;
            end else begin
              state <= S_PRESS_DB;
              cnt   <= CW'(1);
            end
          end
        S_PRESS_DB:
          if (ks) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= S_HELD;
            cnt      <= '0;
            press_ok <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        S_HELD:
          if (ks) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state <= S_IDLE;
              cnt   <= '0;
            end else begin
              state <= S_REL_DB;
              cnt   <= CW'(1);
            end
          end
        S_REL_DB:
          if (!ks) begin
            state <= S_HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Tick phase restarts from zero every time auto mode is (re)entered.
  assign tick = auto_active_r && (tcnt == TCNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            tcnt <= '0;
    else if (!auto_active_r) tcnt <= '0;
    else if (tick)           tcnt <= '0;
    else                     tcnt <= tcnt + TW'(1);
  end

  assign src = auto_active_r ? tick : press_ok;

  always_comb begin
    idx_nxt = idx_r;
    if (bus.dir_up) idx_nxt = (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
    else            idx_nxt = (idx_r == 3'd0) ? IDX_LAST : idx_r - 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_r    <= 1'b0;
      step_up_r <= 1'b0;
      idx_r     <= 3'd0;
    end else begin
      step_r <= src;
      if (src) begin
        step_up_r <= bus.dir_up;
        idx_r     <= idx_nxt;
      end
    end
  end

  assign bus.step        = step_r;
  assign bus.step_up     = step_up_r;
  assign bus.idx         = idx_r;
  assign bus.auto_active = auto_active_r;
endmodule
